// File: rtl/mem_wb_stage_if.sv
// EX/MEM -> MEM/WB boundary bundle: EX/MEM latch contents and squash in,
// MEM/WB latch, register-file write port, status flags and debug read out.
interface mem_wb_stage_if #(
   parameter int AW = 10
);
   // EX/MEM latch as seen by the MEM stage
   logic          ex_mem_valid;
   logic [2:0]    ex_mem_type;
   logic [31:0]   ex_mem_ir;
   logic [31:0]   ex_mem_aluout;
   logic [31:0]   ex_mem_b;
   logic          taken_branch;

   // MEM/WB latch, exported for forwarding/hazard logic
   logic [2:0]    mem_wb_type;
   logic [31:0]   mem_wb_aluout;
   logic [31:0]   mem_wb_lmd;

   // register-file write port
   logic          wb_we;
   logic [4:0]    wb_addr;
   logic [31:0]   wb_data;

   // status
   logic          halted;
   logic          mem_err;

   // debug peek into data memory
   logic [AW-1:0] dbg_addr;
   logic [31:0]   dbg_data;

   // upstream side: EX stage / branch logic / debugger
   modport master (
      output ex_mem_valid, ex_mem_type, ex_mem_ir, ex_mem_aluout, ex_mem_b,
             taken_branch, dbg_addr,
      input  mem_wb_type, mem_wb_aluout, mem_wb_lmd,
             wb_we, wb_addr, wb_data, halted, mem_err, dbg_data
   );

   // the MEM/WB stage itself
   modport slave (
      input  ex_mem_valid, ex_mem_type, ex_mem_ir, ex_mem_aluout, ex_mem_b,
             taken_branch, dbg_addr,
      output mem_wb_type, mem_wb_aluout, mem_wb_lmd,
             wb_we, wb_addr, wb_data, halted, mem_err, dbg_data
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM + WB back half of the pipe_MIPS32 pipeline.
// Owns the data memory, latches MEM/WB, drives the register-file write port
// and the sticky HALTED / memory-error flags. Wrong-path instructions flagged
// by the branch logic, and anything behind a retiring HALT, never commit.
module mem_wb_stage #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic           clk1,
   input  logic           rst,
   mem_wb_stage_if.slave  bus
);

   localparam logic [2:0] T_RR_ALU = 3'b000;
   localparam logic [2:0] T_RM_ALU = 3'b001;
   localparam logic [2:0] T_LOAD   = 3'b010;
   localparam logic [2:0] T_STORE  = 3'b011;
   localparam logic [2:0] T_HALT   = 3'b101;

   typedef enum logic {S_RUN, S_HALT} state_t;

   // MEM/WB latch; only the register fields of the instruction word are kept
   typedef struct packed {
      logic        valid;
      logic [2:0]  typ;
      logic [4:0]  rd;
      logic [4:0]  rt;
      logic [31:0] aluout;
   } mw_t;

   state_t      state;
   mw_t         mw;
   logic [31:0] lmd;
   logic        wb_we_q;
   logic [4:0]  wb_addr_q;
   logic [31:0] wb_data_q;
   logic        halted_q;
   logic        mem_err_q;

   logic [31:0] dmem [DEPTH];

   // MEM-stage decode
   logic          run;
   logic          wb_halt;
   logic          mvalid;
   logic          in_range;
   logic [AW-1:0] maddr;
   logic          is_load;
   logic          is_store;
   logic          do_store;

   // WB next-state
   logic          wb_we_n;
   logic [4:0]    wb_addr_n;
   logic [31:0]   wb_data_n;

   // rs, opcode and funct/immediate bits play no part here
   logic unused_ir;
   assign unused_ir = ^{bus.ex_mem_ir[31:21], bus.ex_mem_ir[10:0]};

   assign run      = (state == S_RUN);
   // a valid HALT sitting in WB retires on this edge and kills whatever is behind it
   assign wb_halt  = mw.valid && (mw.typ == T_HALT);
   assign mvalid   = bus.ex_mem_valid && !bus.taken_branch && !wb_halt;
   // full-width compare so huge addresses are not aliased by truncation
   assign in_range = (bus.ex_mem_aluout < 32'(DEPTH));
   assign maddr    = bus.ex_mem_aluout[AW-1:0];
   assign is_load  = (bus.ex_mem_type == T_LOAD);
   assign is_store = (bus.ex_mem_type == T_STORE);
   assign do_store = run && mvalid && is_store && in_range;

   // WB mux: destination and data chosen by the latched type; r0 never written
   always_comb begin
      wb_addr_n = '0;
      wb_data_n = '0;
      wb_we_n   = 1'b0;
      unique case (mw.typ)
         T_RR_ALU: begin
            wb_addr_n = mw.rd;
            wb_data_n = mw.aluout;
         end
         T_RM_ALU: begin
            wb_addr_n = mw.rt;
            wb_data_n = mw.aluout;
         end
         T_LOAD: begin
            wb_addr_n = mw.rt;
            wb_data_n = lmd;
         end
         default: begin
            wb_addr_n = '0;
            wb_data_n = '0;
         end
      endcase
      if (mw.valid && (mw.typ == T_RR_ALU || mw.typ == T_RM_ALU || mw.typ == T_LOAD))
         wb_we_n = (wb_addr_n != 5'd0);
   end

   // data memory write port; contents survive reset and freeze once halted
   always_ff @(posedge clk1) begin
      if (!rst && do_store)
         dmem[maddr] <= bus.ex_mem_b;
   end

   // RUN/HALT controller with MEM and WB latches and sticky flags
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state     <= S_RUN;
         mw        <= '0;
         lmd       <= '0;
         wb_we_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         halted_q  <= 1'b0;
         mem_err_q <= 1'b0;
      end else if (run) begin
         // MEM -> MEM/WB latch
         mw.valid  <= mvalid;
         mw.typ    <= bus.ex_mem_type;
         mw.rd     <= bus.ex_mem_ir[15:11];
         mw.rt     <= bus.ex_mem_ir[20:16];
         mw.aluout <= bus.ex_mem_aluout;
         if (mvalid && is_load)
            lmd <= in_range ? dmem[maddr] : '0;
         if (mvalid && (is_load || is_store) && !in_range)
            mem_err_q <= 1'b1;

         // WB: a retiring HALT replaces the normal writeback update
         if (wb_halt) begin
            state    <= S_HALT;
            halted_q <= 1'b1;
            wb_we_q  <= 1'b0;
         end else begin
            wb_we_q   <= wb_we_n;
            wb_addr_q <= wb_addr_n;
            wb_data_q <= wb_data_n;
         end
      end else begin
         // halted: everything holds, no further register writes
         wb_we_q <= 1'b0;
      end
   end

   assign bus.mem_wb_type   = mw.typ;
   assign bus.mem_wb_aluout = mw.aluout;
   assign bus.mem_wb_lmd    = lmd;
   assign bus.wb_we         = wb_we_q;
   assign bus.wb_addr       = wb_addr_q;
   assign bus.wb_data       = wb_data_q;
   assign bus.halted        = halted_q;
   assign bus.mem_err       = mem_err_q;
   assign bus.dbg_data      = dmem[bus.dbg_addr];

endmodule
